// File: rtl/fetch_pc_predictor.sv
// fetch_pc_predictor
//   Instruction-fetch front end. It holds the 12-bit fetch PC and a
//   direct-mapped BTB with a 2-bit saturating counter per entry. It picks the
//   next PC from, in priority order: EX redirect, stall hold, BTB prediction,
//   sequential flow. The BTB is trained from branch resolutions reported by EX.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   riscv_start, riscv_done    run = riscv_start && !riscv_done; otherwise frozen
//   *_stall (x4)               hold the fetch PC
//   flush, redirect_pc         redirect from EX; wins over every stall
//   upd_valid, upd_pc,
//   upd_taken, upd_target      branch resolution used to train the BTB
//   pc_in, pc_plus_4           current fetch PC and PC+4 (mod 4096)
//   btb_hit, predict_taken,
//   pred_target                combinational BTB lookup on pc_in
module fetch_pc_predictor #(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [11:0] RESET_PC    = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        riscv_start,
  input  logic        riscv_done,
  input  logic        icache_stall,
  input  logic        dcache_stall,
  input  logic        md_alu_stall,
  input  logic        load_use_stall,
  input  logic        flush,
  input  logic [11:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [11:0] upd_pc,
  input  logic        upd_taken,
  input  logic [11:0] upd_target,
  output logic [11:0] pc_in,
  output logic [11:0] pc_plus_4,
  output logic        predict_taken,
  output logic        btb_hit,
  output logic [11:0] pred_target
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 10 - IDX;

  // Word-aligned PCs: the two low bits are always zero, so they are not stored.
  logic                   btb_valid  [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [9:0]             btb_target [BTB_ENTRIES];

  logic                   run;
  logic                   any_stall;
  logic [11:0]            next_pc;

  logic [IDX-1:0]         fetch_idx;
  logic [TAG_W-1:0]       fetch_tag;
  logic [IDX-1:0]         upd_idx;
  logic [TAG_W-1:0]       upd_tag;
  logic                   upd_hit;
  logic [1:0]             upd_ctr_next;

  // Low address bits of incoming PCs are defined as don't-care.
  logic                   unused_low_bits;
  assign unused_low_bits = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign run       = riscv_start && !riscv_done;
  assign any_stall = icache_stall || dcache_stall || md_alu_stall || load_use_stall;

  // ---------------------------------------------------------------------------
  // Lookup on the current fetch PC (pre-update contents in the update cycle).
  // ---------------------------------------------------------------------------
  assign fetch_idx     = pc_in[IDX+1:2];
  assign fetch_tag     = pc_in[11:IDX+2];
  assign btb_hit       = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
  assign predict_taken = btb_hit && btb_ctr[fetch_idx][1];
  assign pred_target   = {btb_target[fetch_idx], 2'b00};
  assign pc_plus_4     = pc_in + 12'd4;

  // ---------------------------------------------------------------------------
  // Next-PC selection.
  // ---------------------------------------------------------------------------
  // NOTE: next_pc gets a default first so no path leaves it unassigned; a
  // missing branch in always_comb would otherwise infer a latch.
  always_comb begin
    next_pc = pc_in;
    if (flush) begin
      next_pc = {redirect_pc[11:2], 2'b00};
    end else if (any_stall) begin
      next_pc = pc_in;
    end else if (predict_taken) begin
      next_pc = pred_target;
    end else begin
      next_pc = pc_plus_4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_in <= RESET_PC;
    end else if (run) begin
      pc_in <= next_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // BTB training.
  // ---------------------------------------------------------------------------
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[11:IDX+2];
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  always_comb begin
    upd_ctr_next = btb_ctr[upd_idx];
    if (upd_taken) begin
      if (btb_ctr[upd_idx] != 2'd3) upd_ctr_next = btb_ctr[upd_idx] + 2'd1;
    end else begin
      if (btb_ctr[upd_idx] != 2'd0) upd_ctr_next = btb_ctr[upd_idx] - 2'd1;
    end
  end

  // NOTE: the whole table is cleared on reset, not just the valid bits, so
  // pred_target and the counters read as defined values straight after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_ctr[i]    <= 2'b01;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (run && upd_valid) begin
      if (upd_hit) begin
        btb_ctr[upd_idx] <= upd_ctr_next;
        if (upd_taken) btb_target[upd_idx] <= upd_target[11:2];
      end else if (upd_taken) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= upd_target[11:2];
        btb_ctr[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
module tb_fetch_pc_predictor;

  localparam int ENTRIES = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        riscv_start, riscv_done;
  logic        icache_stall, dcache_stall, md_alu_stall, load_use_stall;
  logic        flush;
  logic [11:0] redirect_pc;
  logic        upd_valid;
  logic [11:0] upd_pc;
  logic        upd_taken;
  logic [11:0] upd_target;
  logic [11:0] pc_in, pc_plus_4, pred_target;
  logic        predict_taken, btb_hit;

  always #5 clk = ~clk;

  fetch_pc_predictor #(.BTB_ENTRIES(ENTRIES), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset),
    .riscv_start(riscv_start), .riscv_done(riscv_done),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .md_alu_stall(md_alu_stall), .load_use_stall(load_use_stall),
    .flush(flush), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .pc_in(pc_in), .pc_plus_4(pc_plus_4), .predict_taken(predict_taken),
    .btb_hit(btb_hit), .pred_target(pred_target)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: table of entries addressed by plain arithmetic on the PC.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit valid;
    int tag;
    int target;
    int ctr;
  } entry_t;

  entry_t m_btb[ENTRIES];
  int     m_pc;

  function automatic int m_index(input int pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int m_tagof(input int pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < ENTRIES; i++) m_btb[i] = '{valid: 1'b0, tag: 0, target: 0, ctr: 1};
  endtask

  task automatic idle_inputs();
    reset = 0; riscv_start = 1; riscv_done = 0;
    icache_stall = 0; dcache_stall = 0; md_alu_stall = 0; load_use_stall = 0;
    flush = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
  endtask

  // Called just after a falling edge with inputs already driven: compares the
  // outputs against the model, advances one clock, and leaves time at the
  // next falling edge.
  task automatic step();
    int  idx, nxt, ui, upc, utgt;
    bit  hit, pt, run, uhit;
    #1;
    idx = m_index(m_pc);
    hit = m_btb[idx].valid && (m_btb[idx].tag == m_tagof(m_pc));
    pt  = hit && (m_btb[idx].ctr >= 2);
    check("pc_in",         32'(pc_in),         32'(m_pc));
    check("pc_plus_4",     32'(pc_plus_4),     32'((m_pc + 4) % 4096));
    check("btb_hit",       32'(btb_hit),       32'(hit));
    check("predict_taken", 32'(predict_taken), 32'(pt));
    check("pred_target",   32'(pred_target),   32'(m_btb[idx].target));

    run = riscv_start && !riscv_done;
    if (flush)                                                   nxt = int'(redirect_pc) & 'hFFC;
    else if (icache_stall || dcache_stall || md_alu_stall || load_use_stall) nxt = m_pc;
    else if (pt)                                                 nxt = m_btb[idx].target;
    else                                                         nxt = (m_pc + 4) % 4096;

    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (run) begin
      m_pc = nxt;
      if (upd_valid) begin
        upc  = int'(upd_pc) & 'hFFC;
        utgt = int'(upd_target) & 'hFFC;
        ui   = m_index(upc);
        uhit = m_btb[ui].valid && (m_btb[ui].tag == m_tagof(upc));
        if (uhit) begin
          if (upd_taken) begin
            m_btb[ui].ctr    = (m_btb[ui].ctr == 3) ? 3 : m_btb[ui].ctr + 1;
            m_btb[ui].target = utgt;
          end else begin
            m_btb[ui].ctr = (m_btb[ui].ctr == 0) ? 0 : m_btb[ui].ctr - 1;
          end
        end else if (upd_taken) begin
          m_btb[ui] = '{valid: 1'b1, tag: m_tagof(upc), target: utgt, ctr: 2};
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic train(input logic [11:0] pc, input logic taken, input logic [11:0] tgt);
    upd_valid = 1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
  endtask

  task automatic redirect(input logic [11:0] pc);
    flush = 1; redirect_pc = pc;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    reset = 1;
    @(negedge clk);
    reset = 1; step();
    reset = 1; step();

    // 1: sequential fetch from reset, nothing predicted.
    check("s1_pc0", 32'(pc_in), 32'h000);
    check("s1_hit0", 32'(btb_hit), 0);
    step();
    check("s1_pc1", 32'(pc_in), 32'h004);
    // 2: train 0x010 -> 0x040 while fetching towards it.
    train(12'h010, 1, 12'h040); step();
    check("s1_pc2", 32'(pc_in), 32'h008);
    step();                                      // pc 0x00C
    step();                                      // pc 0x010
    #1;
    check("s2_hit", 32'(btb_hit), 1);
    check("s2_pt", 32'(predict_taken), 1);
    step();
    check("s2_redirected", 32'(pc_in), 32'h040);

    // 3: two not-taken updates saturate down to 0; a third keeps it at 0.
    train(12'h010, 0, 12'h000); step();
    train(12'h010, 0, 12'h000); redirect(12'h010); step();
    #1;
    check("s3_hit", 32'(btb_hit), 1);
    check("s3_pt", 32'(predict_taken), 0);
    train(12'h010, 0, 12'h000); step();
    check("s3_seq", 32'(pc_in), 32'h014);
    redirect(12'h010); step();
    #1;
    check("s3_sat_pt", 32'(predict_taken), 0);
    step();

    // 4: flush beats stall, then stall holds.
    redirect(12'h100); icache_stall = 1; step();
    check("s4_flush", 32'(pc_in), 32'h100);
    for (int i = 0; i < 3; i++) begin
      icache_stall = 1; step();
      check("s4_hold", 32'(pc_in), 32'h100);
    end

    // 5: aliasing on index 4: 0x050 replaces 0x010.
    train(12'h050, 1, 12'h080); redirect(12'h010); step();
    #1;
    check("s5_old_miss", 32'(btb_hit), 0);
    redirect(12'h050); step();
    #1;
    check("s5_new_hit", 32'(btb_hit), 1);
    check("s5_target", 32'(pred_target), 32'h080);
    step();

    // 6: wrap, done freeze, reset mid-stall.
    redirect(12'hFFC); step();
    step();
    check("s6_wrap", 32'(pc_in), 32'h000);
    riscv_done = 1; redirect(12'h300); train(12'h000, 1, 12'h200); step();
    check("s6_frozen", 32'(pc_in), 32'h000);
    step();
    #1;
    check("s6_no_train", 32'(btb_hit), 0);
    redirect(12'h050); step();
    icache_stall = 1; reset = 1; step();
    check("s6_reset_pc", 32'(pc_in), 32'h000);
    redirect(12'h050); step();
    #1;
    check("s6_reset_inval", 32'(btb_hit), 0);
    step();

    // Randomized traffic over a narrow address window to force hits/aliasing.
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(99) < 2);
      riscv_start    = ($urandom_range(99) < 95);
      riscv_done     = ($urandom_range(99) < 5);
      icache_stall   = ($urandom_range(99) < 10);
      dcache_stall   = ($urandom_range(99) < 5);
      md_alu_stall   = ($urandom_range(99) < 5);
      load_use_stall = ($urandom_range(99) < 5);
      flush          = ($urandom_range(99) < 15);
      redirect_pc    = ($urandom_range(9) == 0) ? 12'($urandom) : 12'($urandom_range(255));
      upd_valid      = ($urandom_range(99) < 40);
      upd_pc         = ($urandom_range(9) == 0) ? 12'($urandom) : 12'($urandom_range(255));
      upd_taken      = $urandom_range(1);
      upd_target     = 12'($urandom_range(255));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the run so a broken design cannot hang the bench.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
